// File: rtl/dio_frame_serializer.sv
// -----------------------------------------------------------------------------
// dio_frame_serializer
//
// Upstream stage of the breakout LVDS link. The digital inputs are brought
// into the CLK domain through a two-flop synchronizer. A frame is sent
// whenever the synchronized value differs from the last value sent, or
// after HEARTBEAT idle cycles with no change.
//
// Frame layout (MSB first, FRAME_BITS = DATA_W + 3 bits):
//   '1', '0', data[DATA_W-1:0], even parity of the data bits
//
// Parameters:
//   DATA_W     width of D_IN and of the frame payload
//   CLK_DIV    CLK cycles per serial bit (>= 1)
//   HEARTBEAT  idle cycles before an unchanged value is resent; 0 disables
//
// Ports:
//   CLK      in   system clock
//   RESET_N  in   asynchronous assert, active-low reset
//   D_IN     in   asynchronous digital inputs (DATA_W bits)
//   SDO      out  serial data, registered
//   SYNC     out  high for every cycle of a frame's bit periods
//   BIT_STB  out  one-cycle pulse in the first CLK of each frame bit
//   BUSY     out  high while shifting a frame and during the trailing gap
// -----------------------------------------------------------------------------
module dio_frame_serializer #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 2,
    parameter int HEARTBEAT = 1000
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] D_IN,
    output logic              SDO,
    output logic              SYNC,
    output logic              BIT_STB,
    output logic              BUSY
);

    localparam int FRAME_BITS = DATA_W + 3;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // Only needs to reach HEARTBEAT-1; the counter saturates instead of
    // wrapping so a disabled heartbeat can idle forever.
    localparam int HB_W       = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'((HEARTBEAT > 0) ? (HEARTBEAT - 1) : 0);
    localparam logic [HB_W-1:0]  HB_ONE   = HB_W'(1);
    localparam logic [HB_W-1:0]  HB_MAX   = '1;
    localparam bit               HB_EN    = (HEARTBEAT != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Even parity: 1 when the data holds an odd number of ones.
    function automatic logic even_parity(input logic [DATA_W-1:0] v);
        return ^v;
    endfunction

    // Full frame image, header first.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_W-1:0] v);
        return {2'b10, v, even_parity(v)};
    endfunction

    state_t                state_q,   state_d;
    logic [DATA_W-1:0]     sync1_q,   sync1_d;
    logic [DATA_W-1:0]     ds_q,      ds_d;
    logic [DATA_W-1:0]     d_last_q,  d_last_d;
    logic [FRAME_BITS-1:0] sh_q,      sh_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [HB_W-1:0]       hb_cnt_q,  hb_cnt_d;
    logic                  sdo_q,     sdo_d;
    logic                  sync_q,    sync_d;
    logic                  stb_q,     stb_d;
    logic                  busy_q,    busy_d;

    logic                  value_changed;
    logic                  hb_due;
    logic                  start_frame;
    logic [FRAME_BITS-1:0] frame_w;

    assign value_changed = (ds_q != d_last_q);
    assign hb_due        = HB_EN && (hb_cnt_q == HB_LAST);
    // A change and a heartbeat landing together still give a single frame.
    assign start_frame   = value_changed || hb_due;
    assign frame_w       = build_frame(ds_q);

    always_comb begin
        state_d   = state_q;
        sync1_d   = D_IN;
        ds_d      = sync1_q;
        d_last_d  = d_last_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        hb_cnt_d  = hb_cnt_q;
        sdo_d     = sdo_q;
        sync_d    = sync_q;
        stb_d     = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (hb_cnt_q != HB_MAX) begin
                    hb_cnt_d = hb_cnt_q + HB_ONE;
                end
                if (start_frame) begin
                    // The header's first bit goes out on the same edge that
                    // leaves IDLE, so SYNC and SDO rise together.
                    state_d   = ST_SHIFT;
                    sh_d      = frame_w;
                    d_last_d  = ds_q;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    sdo_d     = frame_w[FRAME_BITS-1];
                    sync_d    = 1'b1;
                    stb_d     = 1'b1;
                    busy_d    = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (div_cnt_q == LAST_DIV) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_GAP;
                        sdo_d   = 1'b0;
                        sync_d  = 1'b0;
                    end else begin
                        // sh_q still holds the bit on SDO at its MSB, so the
                        // next bit to send sits one position below it.
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                        sh_d      = sh_q << 1;
                        sdo_d     = sh_q[FRAME_BITS-2];
                        stb_d     = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_ONE;
                end
            end

            ST_GAP: begin
                if (div_cnt_q == LAST_DIV) begin
                    state_d   = ST_IDLE;
                    div_cnt_d = '0;
                    hb_cnt_d  = '0;
                    busy_d    = 1'b0;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_ONE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                hb_cnt_d  = '0;
                sdo_d     = 1'b0;
                sync_d    = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            sync1_q   <= '0;
            ds_q      <= '0;
            d_last_q  <= '0;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            hb_cnt_q  <= '0;
            sdo_q     <= 1'b0;
            sync_q    <= 1'b0;
            stb_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            ds_q      <= ds_d;
            d_last_q  <= d_last_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            hb_cnt_q  <= hb_cnt_d;
            sdo_q     <= sdo_d;
            sync_q    <= sync_d;
            stb_q     <= stb_d;
            busy_q    <= busy_d;
        end
    end

    assign SDO     = sdo_q;
    assign SYNC    = sync_q;
    assign BIT_STB = stb_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_dio_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_dio_frame_serializer
//
// Drives dio_frame_serializer (defaults) and a second instance with the
// heartbeat disabled. A frame-level reference model predicts, for every
// clock edge, the registered SDO/SYNC/BIT_STB/BUSY values from the input
// history: frame start times, the value carried, and the bit timing inside
// a frame are derived from plain arithmetic on edge counts.
// -----------------------------------------------------------------------------
module tb_dio_frame_serializer;

    localparam int DW   = 8;
    localparam int CD   = 2;
    localparam int HB   = 1000;
    localparam int FB   = DW + 3;
    localparam int FLEN = FB * CD;
    localparam int TOT  = FLEN + CD;

    logic          CLK      = 1'b0;
    logic          RESET_N  = 1'b0;
    logic [DW-1:0] D_IN     = '0;
    logic          SDO, SYNC, BIT_STB, BUSY;

    logic          RESET_N2 = 1'b0;
    logic [DW-1:0] D_IN2    = '0;
    logic          SDO2, SYNC2, BIT_STB2, BUSY2;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    dio_frame_serializer #(.DATA_W(DW), .CLK_DIV(CD), .HEARTBEAT(HB)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .D_IN(D_IN),
        .SDO(SDO), .SYNC(SYNC), .BIT_STB(BIT_STB), .BUSY(BUSY)
    );

    dio_frame_serializer #(.DATA_W(DW), .CLK_DIV(1), .HEARTBEAT(0)) u_dut_nohb (
        .CLK(CLK), .RESET_N(RESET_N2), .D_IN(D_IN2),
        .SDO(SDO2), .SYNC(SYNC2), .BIT_STB(BIT_STB2), .BUSY(BUSY2)
    );

    // ---------------- reference model state ----------------
    int            n_edge;
    int            m_start;
    int            m_idle_begin;
    bit            m_active;
    logic [DW-1:0] dh1, dh2, m_last, m_frame;

    // ---------------- observer state ----------------
    logic          prev_sync;
    logic [FB-1:0] cur_bits;
    int            rises[$];
    logic [FB-1:0] frames[$];
    int            stb_total;
    int            sync_total;

    function automatic logic frame_bit(input logic [DW-1:0] v, input int i);
        if (i == 0)      return 1'b1;
        if (i == 1)      return 1'b0;
        if (i == FB - 1) return ($countones(v) % 2) == 1;
        return v[DW - 1 - (i - 2)];
    endfunction

    function automatic void model_reset();
        n_edge       = 0;
        dh1          = '0;
        dh2          = '0;
        m_last       = '0;
        m_frame      = '0;
        m_active     = 1'b0;
        m_start      = 0;
        m_idle_begin = 1;
    endfunction

    function automatic void obs_clear();
        rises.delete();
        frames.delete();
        cur_bits   = '0;
        stb_total  = 0;
        sync_total = 0;
        prev_sync  = SYNC;
    endfunction

    // Apply d for one clock, advance the model to the new edge and return
    // the expected {SDO, SYNC, BIT_STB, BUSY}; also records what the DUT did.
    task automatic tick(input logic [DW-1:0] d, output logic [3:0] exp);
        int p;
        int hb;
        logic [DW-1:0] ds;
        D_IN = d;
        @(posedge CLK);
        n_edge++;
        ds  = dh2;
        dh2 = dh1;
        dh1 = d;
        if (m_active && n_edge >= m_start + TOT) begin
            m_active     = 1'b0;
            m_idle_begin = m_start + TOT + 1;
        end
        if (!m_active && n_edge >= m_idle_begin) begin
            hb = n_edge - m_idle_begin;
            if (ds != m_last || (HB != 0 && hb == HB - 1)) begin
                m_active = 1'b1;
                m_start  = n_edge;
                m_frame  = ds;
                m_last   = ds;
            end
        end
        exp = 4'b0000;
        if (m_active) begin
            p = n_edge - m_start;
            if (p < FLEN) exp = {frame_bit(m_frame, p / CD), 1'b1, (p % CD) == 0, 1'b1};
            else          exp = 4'b0001;
        end
        #1;
        if (BIT_STB) cur_bits = {cur_bits[FB-2:0], SDO};
        if (SYNC && !prev_sync) rises.push_back(n_edge);
        if (!SYNC && prev_sync) frames.push_back(cur_bits);
        if (SYNC) sync_total++;
        if (BIT_STB) stb_total++;
        prev_sync = SYNC;
    endtask

    task automatic do_reset(input logic [DW-1:0] d);
        RESET_N = 1'b0;
        D_IN    = d;
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        model_reset();
        obs_clear();
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        RESET_N  = 1'b1;
        RESET_N2 = 1'b1;
        D_IN     = 8'h5A;
        repeat (3) @(posedge CLK);
        #3;
        RESET_N  = 1'b0;
        RESET_N2 = 1'b0;
        #1;
        checks++;
        if ({SDO, SYNC, BIT_STB, BUSY} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_async got=%b exp=0000", {SDO, SYNC, BIT_STB, BUSY});
        end
        checks++;
        if ({SDO2, SYNC2, BIT_STB2, BUSY2} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_async_nohb got=%b exp=0000", {SDO2, SYNC2, BIT_STB2, BUSY2});
        end
        do_reset(8'h00);
        for (int i = 0; i < 6; i++) begin
            tick(8'h00, exp);
            checks++;
            if ({SDO, SYNC, BIT_STB, BUSY} !== exp) begin
                failures++;
                $display("FAIL reset_idle edge=%0d got=%b exp=%b", n_edge, {SDO, SYNC, BIT_STB, BUSY}, exp);
            end
        end
    endtask

    task automatic test_single_change();
        logic [3:0] exp;
        int k;
        do_reset(8'h00);
        for (int i = 0; i < 3; i++) begin
            tick(8'h00, exp);
            checks++;
            if ({SDO, SYNC, BIT_STB, BUSY} !== exp) begin
                failures++;
                $display("FAIL single_cycle edge=%0d got=%b exp=%b", n_edge, {SDO, SYNC, BIT_STB, BUSY}, exp);
            end
        end
        k = n_edge + 1;
        for (int i = 0; i < 30; i++) begin
            tick(8'h01, exp);
            checks++;
            if ({SDO, SYNC, BIT_STB, BUSY} !== exp) begin
                failures++;
                $display("FAIL single_cycle edge=%0d got=%b exp=%b", n_edge, {SDO, SYNC, BIT_STB, BUSY}, exp);
            end
        end
        checks++;
        if (rises.size() != 1 || rises[0] != k + 2) begin
            failures++;
            $display("FAIL single_latency rises=%0d first=%0d exp_edge=%0d", rises.size(),
                     (rises.size() > 0) ? rises[0] : -1, k + 2);
        end
        checks++;
        if (sync_total != 22) begin
            failures++;
            $display("FAIL single_sync_len got=%0d exp=22", sync_total);
        end
        checks++;
        if (stb_total != 11) begin
            failures++;
            $display("FAIL single_stb_count got=%0d exp=11", stb_total);
        end
        checks++;
        if (frames.size() != 1 || frames[0] !== 11'b10_00000001_1) begin
            failures++;
            $display("FAIL single_bits n=%0d got=%b exp=%b", frames.size(),
                     (frames.size() > 0) ? frames[0] : 11'bx, 11'b10_00000001_1);
        end
    endtask

    task automatic test_heartbeat();
        logic [3:0] exp;
        do_reset(8'h00);
        for (int i = 0; i < HB + 2 * (TOT + HB) + 5; i++) begin
            tick(8'h00, exp);
            checks++;
            if ({SDO, SYNC, BIT_STB, BUSY} !== exp) begin
                failures++;
                $display("FAIL hb_cycle edge=%0d got=%b exp=%b", n_edge, {SDO, SYNC, BIT_STB, BUSY}, exp);
            end
        end
        checks++;
        if (rises.size() != 3) begin
            failures++;
            $display("FAIL hb_count got=%0d exp=3", rises.size());
        end else begin
            checks++;
            if (rises[0] != 1000) begin
                failures++;
                $display("FAIL hb_first got=%0d exp=1000", rises[0]);
            end
            checks++;
            if (rises[1] != 2024 || rises[2] != 3048) begin
                failures++;
                $display("FAIL hb_period got=%0d,%0d exp=2024,3048", rises[1], rises[2]);
            end
        end
        checks++;
        if (frames.size() != 2 || frames[0] !== 11'b10_00000000_0 || frames[1] !== 11'b10_00000000_0) begin
            failures++;
            $display("FAIL hb_payload n=%0d got=%b exp=%b", frames.size(),
                     (frames.size() > 0) ? frames[0] : 11'bx, 11'b10_00000000_0);
        end
    endtask

    task automatic test_coalesce();
        logic [3:0] exp;
        logic [DW-1:0] d;
        do_reset(8'h00);
        for (int i = 0; i < 2 * TOT + 20; i++) begin
            d = (i < 2) ? 8'h00 : (i < 8) ? 8'hA5 : (i < 14) ? 8'h3C : 8'hFF;
            tick(d, exp);
            checks++;
            if ({SDO, SYNC, BIT_STB, BUSY} !== exp) begin
                failures++;
                $display("FAIL coalesce_cycle edge=%0d got=%b exp=%b", n_edge, {SDO, SYNC, BIT_STB, BUSY}, exp);
            end
        end
        checks++;
        if (frames.size() != 2 || frames[0] !== 11'b10_10100101_0 || frames[1] !== 11'b10_11111111_0) begin
            failures++;
            $display("FAIL coalesce_frames n=%0d got0=%b got1=%b exp=%b,%b", frames.size(),
                     (frames.size() > 0) ? frames[0] : 11'bx, (frames.size() > 1) ? frames[1] : 11'bx,
                     11'b10_10100101_0, 11'b10_11111111_0);
        end
    endtask

    task automatic test_return_to_last();
        logic [3:0] exp;
        logic [DW-1:0] d;
        do_reset(8'h00);
        for (int i = 0; i < 5 + TOT + HB + TOT + 5; i++) begin
            d = (i < 2) ? 8'h00 : (i < 8) ? 8'h01 : (i < 14) ? 8'h02 : 8'h01;
            tick(d, exp);
            checks++;
            if ({SDO, SYNC, BIT_STB, BUSY} !== exp) begin
                failures++;
                $display("FAIL return_cycle edge=%0d got=%b exp=%b", n_edge, {SDO, SYNC, BIT_STB, BUSY}, exp);
            end
        end
        checks++;
        if (rises.size() != 2 || rises[1] - rises[0] != 1024) begin
            failures++;
            $display("FAIL return_spacing n=%0d gap=%0d exp=1024", rises.size(),
                     (rises.size() > 1) ? rises[1] - rises[0] : -1);
        end
        checks++;
        if (frames.size() != 2 || frames[0] !== 11'b10_00000001_1 || frames[1] !== 11'b10_00000001_1) begin
            failures++;
            $display("FAIL return_frames n=%0d got=%b exp=%b", frames.size(),
                     (frames.size() > 1) ? frames[1] : 11'bx, 11'b10_00000001_1);
        end
    endtask

    task automatic test_reset_midframe();
        logic [3:0] exp;
        bit found;
        do_reset(8'h80);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(8'h80, exp);
            checks++;
            if ({SDO, SYNC, BIT_STB, BUSY} !== exp) begin
                failures++;
                $display("FAIL midframe_cycle edge=%0d got=%b exp=%b", n_edge, {SDO, SYNC, BIT_STB, BUSY}, exp);
            end
            if (m_active && (n_edge - m_start) == 5 * CD) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL midframe_reach got=0 exp=1");
        end
        #2;
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({SDO, SYNC, BIT_STB, BUSY} !== 4'b0000) begin
            failures++;
            $display("FAIL midframe_drop got=%b exp=0000", {SDO, SYNC, BIT_STB, BUSY});
        end
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        model_reset();
        obs_clear();
        for (int i = 0; i < 40; i++) begin
            tick(8'h80, exp);
            checks++;
            if ({SDO, SYNC, BIT_STB, BUSY} !== exp) begin
                failures++;
                $display("FAIL midframe_retx edge=%0d got=%b exp=%b", n_edge, {SDO, SYNC, BIT_STB, BUSY}, exp);
            end
        end
        checks++;
        if (rises.size() != 1 || rises[0] != 3) begin
            failures++;
            $display("FAIL midframe_restart n=%0d edge=%0d exp=3", rises.size(),
                     (rises.size() > 0) ? rises[0] : -1);
        end
        checks++;
        if (frames.size() != 1 || frames[0] !== 11'b10_10000000_1) begin
            failures++;
            $display("FAIL midframe_frame got=%b exp=%b",
                     (frames.size() > 0) ? frames[0] : 11'bx, 11'b10_10000000_1);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp;
        logic [DW-1:0] d;
        logic [DW-1:0] prev_d;
        int hold;
        do_reset(8'h00);
        d      = '0;
        prev_d = '0;
        hold   = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0:       d = 8'h00;
                    1:       d = prev_d;
                    default: d = DW'($urandom);
                endcase
                prev_d = D_IN;
                hold   = $urandom_range(1, 40);
            end
            hold--;
            tick(d, exp);
            checks++;
            if ({SDO, SYNC, BIT_STB, BUSY} !== exp) begin
                failures++;
                $display("FAIL random_cycle edge=%0d din=%h got=%b exp=%b", n_edge, d,
                         {SDO, SYNC, BIT_STB, BUSY}, exp);
            end
        end
        checks++;
        if (frames.size() == 0) begin
            failures++;
            $display("FAIL random_activity frames=0 exp>0");
        end
    endtask

    task automatic test_no_heartbeat();
        int sync_seen;
        int e;
        bit hit;
        logic [FB-1:0] bits;
        RESET_N = 1'b0;
        D_IN2   = 8'h00;
        @(posedge CLK);
        #1;
        RESET_N2  = 1'b1;
        sync_seen = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge CLK);
            #1;
            if (SYNC2 || BUSY2) sync_seen++;
        end
        checks++;
        if (sync_seen != 0) begin
            failures++;
            $display("FAIL nohb_quiet got=%0d exp=0", sync_seen);
        end
        D_IN2 = 8'h5A;
        hit   = 1'b0;
        e     = 0;
        while (!hit && e < 10) begin
            @(posedge CLK);
            #1;
            e++;
            if (SYNC2) hit = 1'b1;
        end
        checks++;
        if (!hit || e != 3) begin
            failures++;
            $display("FAIL nohb_latency got=%0d exp=3", hit ? e : -1);
        end
        bits = '0;
        for (int i = 0; i < FB; i++) begin
            bits = {bits[FB-2:0], SDO2};
            @(posedge CLK);
            #1;
        end
        checks++;
        if (bits !== 11'b10_01011010_0) begin
            failures++;
            $display("FAIL nohb_frame got=%b exp=%b", bits, 11'b10_01011010_0);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_change();
        test_heartbeat();
        test_coalesce();
        test_return_to_last();
        test_reset_midframe();
        test_random();
        test_no_heartbeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
